multicycle_controller: RTL and testbench

Control unit for the multicycle RV32I datapath: a Moore/Mealy state machine that sequences fetch, decode, execute, memory and writeback over several cycles instead of one. It generates every datapath enable and mux select, decodes ALU operations, evaluates beq/bne, and stalls on a memory-ready handshake. It sits beside the multicycle datapath and shared instruction/data memory.

---
 rtl/multicycle_controller.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/mem/writeback.
// Define MCCTRL_MEM_WAIT_EN to stall FETCH/MEMREAD/MEMWRITE on MemReady.
module multicycle_controller #(
  parameter int ALUC_W       = 3,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        op,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic              Zero,
  input  logic              MemReady,
  output logic              PCWrite,
  output logic              AdrSrc,
  output logic              MemWrite,
  output logic              IRWrite,
  output logic [1:0]        ResultSrc,
  output logic [1:0]        ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        ImmSrc,
  output logic              RegWrite,
  output logic [ALUC_W-1:0] ALUControl,
  output logic              Illegal
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BRANCH, JAL
  } state_t;

  state_t     state, next;
  logic       mem_ok;
  logic       irw, mw, rw, ill;
  logic       branch, pc_upd, taken;
  logic [1:0] alu_op;
  logic [2:0] alu_code;

`ifdef MCCTRL_MEM_WAIT_EN
  assign mem_ok = MemReady;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = MemReady;
  assign mem_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= next;
  end

  always_comb begin
    next      = state;
    AdrSrc    = 1'b0;
    mw        = 1'b0;
    irw       = 1'b0;
    rw        = 1'b0;
    ill       = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = 2'b00;
    branch    = 1'b0;
    pc_upd    = 1'b0;
    unique case (state)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        irw       = mem_ok;
        pc_upd    = mem_ok;
        if (mem_ok) next = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: next = MEMADR;
          OP_R:         next = EXECR;
          OP_I:         next = EXECI;
          OP_BR:        next = BRANCH;
          OP_JAL:       next = JAL;
          default: begin
            next = FETCH;
            ill  = ILLEGAL_TRAP;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        // lw and sw differ only in opcode bit 5
        next    = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ok) next = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        rw        = 1'b1;
        next      = FETCH;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mw     = 1'b1;
        if (mem_ok) next = FETCH;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
        next    = ALUWB;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
        next    = ALUWB;
      end
      ALUWB: begin
        rw   = 1'b1;
        next = FETCH;
      end
      BRANCH: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
        next    = FETCH;
      end
      JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pc_upd  = 1'b1;
        next    = ALUWB;
      end
      default: next = FETCH;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = !Zero;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BR:   ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    alu_code = 3'b000;
    unique case (alu_op)
      2'b00: alu_code = 3'b000;
      2'b01: alu_code = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alu_code = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
          3'b010:  alu_code = 3'b101;
          3'b110:  alu_code = 3'b011;
          3'b111:  alu_code = 3'b010;
          default: alu_code = 3'b000;
        endcase
      end
      default: alu_code = 3'b000;
    endcase
  end

  assign ALUControl = ALUC_W'(alu_code);

  // Strobes are masked while reset is held so nothing writes during reset
  assign PCWrite  = !reset & ((branch & taken) | pc_upd);
  assign IRWrite  = !reset & irw;
  assign MemWrite = !reset & mw;
  assign RegWrite = !reset & rw;
  assign Illegal  = !reset & ill;

endmodule

// File: tb/tb_multicycle_controller.sv
// Table-driven bench for multicycle_controller with reset and stall sequences.
// Stall sequences depend on MCCTRL_MEM_WAIT_EN.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'h03;
  logic [2:0] funct3 = 3'b010;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b1;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [3:0] ALUControl;

  int applied = 0;
  int miscompares = 0;

  localparam logic [6:0] LW  = 7'h03;
  localparam logic [6:0] SW  = 7'h23;
  localparam logic [6:0] RT  = 7'h33;
  localparam logic [6:0] IT  = 7'h13;
  localparam logic [6:0] BR  = 7'h63;
  localparam logic [6:0] JL  = 7'h6F;
  localparam logic [6:0] BAD = 7'h7F;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic        mr;
    logic [17:0] exp;
  } vec_t;

  vec_t tbl[$];

  multicycle_controller #(.ALUC_W(4), .ILLEGAL_TRAP(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
    .ALUControl(ALUControl), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  // {pcw,adr,mw,irw,rs,sa,sb,imm,rw,alu(4),ill}
  function automatic vec_t v(
    input logic [6:0] o, input logic [2:0] f3,
    input logic f7, input logic z, input logic mr,
    input logic pcw, input logic adr, input logic mw, input logic irw,
    input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
    input logic [1:0] imm, input logic rw, input logic [2:0] alu,
    input logic ill);
    vec_t r;
    r.op = o; r.f3 = f3; r.f7 = f7; r.z = z; r.mr = mr;
    r.exp = {pcw, adr, mw, irw, rs, sa, sb, imm, rw, 1'b0, alu, ill};
    return r;
  endfunction

  function automatic logic [17:0] actual();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
            ALUSrcB, ImmSrc, RegWrite, ALUControl, Illegal};
  endfunction

  task automatic apply(input vec_t t, input string nm);
    op = t.op; funct3 = t.f3; funct7b5 = t.f7;
    Zero = t.z; MemReady = t.mr;
    #1;
    applied++;
    if (actual() !== t.exp) begin
      miscompares++;
      $display("FAIL %s got %h want %h", nm, actual(), t.exp);
    end
  endtask

  task automatic count_check(input int got, input int want, input string nm);
    applied++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  initial begin
    int irw_cnt;
    // lw
    tbl.push_back(v(LW,3'd2,0,0,1, 1,0,0,1,2'd2,2'd0,2'd2,2'd0,0,3'd0,0));
    tbl.push_back(v(LW,3'd2,0,0,1, 0,0,0,0,2'd0,2'd1,2'd1,2'd0,0,3'd0,0));
    tbl.push_back(v(LW,3'd2,0,0,1, 0,0,0,0,2'd0,2'd2,2'd1,2'd0,0,3'd0,0));
    tbl.push_back(v(LW,3'd2,0,0,1, 0,1,0,0,2'd0,2'd0,2'd0,2'd0,0,3'd0,0));
    tbl.push_back(v(LW,3'd2,0,0,1, 0,0,0,0,2'd1,2'd0,2'd0,2'd0,1,3'd0,0));
    // sw
    tbl.push_back(v(SW,3'd2,0,0,1, 1,0,0,1,2'd2,2'd0,2'd2,2'd1,0,3'd0,0));
    tbl.push_back(v(SW,3'd2,0,0,1, 0,0,0,0,2'd0,2'd1,2'd1,2'd1,0,3'd0,0));
    tbl.push_back(v(SW,3'd2,0,0,1, 0,0,0,0,2'd0,2'd2,2'd1,2'd1,0,3'd0,0));
    tbl.push_back(v(SW,3'd2,0,0,1, 0,1,1,0,2'd0,2'd0,2'd0,2'd1,0,3'd0,0));
    // sub
    tbl.push_back(v(RT,3'd0,1,0,1, 1,0,0,1,2'd2,2'd0,2'd2,2'd0,0,3'd0,0));
    tbl.push_back(v(RT,3'd0,1,0,1, 0,0,0,0,2'd0,2'd1,2'd1,2'd0,0,3'd0,0));
    tbl.push_back(v(RT,3'd0,1,0,1, 0,0,0,0,2'd0,2'd2,2'd0,2'd0,0,3'd1,0));
    tbl.push_back(v(RT,3'd0,1,0,1, 0,0,0,0,2'd0,2'd0,2'd0,2'd0,1,3'd0,0));
    // add
    tbl.push_back(v(RT,3'd0,0,0,1, 1,0,0,1,2'd2,2'd0,2'd2,2'd0,0,3'd0,0));
    tbl.push_back(v(RT,3'd0,0,0,1, 0,0,0,0,2'd0,2'd1,2'd1,2'd0,0,3'd0,0));
    tbl.push_back(v(RT,3'd0,0,0,1, 0,0,0,0,2'd0,2'd2,2'd0,2'd0,0,3'd0,0));
    tbl.push_back(v(RT,3'd0,0,0,1, 0,0,0,0,2'd0,2'd0,2'd0,2'd0,1,3'd0,0));
    // and / slt (execute cycle only differs)
    tbl.push_back(v(RT,3'd7,0,0,1, 1,0,0,1,2'd2,2'd0,2'd2,2'd0,0,3'd0,0));
    tbl.push_back(v(RT,3'd7,0,0,1, 0,0,0,0,2'd0,2'd1,2'd1,2'd0,0,3'd0,0));
    tbl.push_back(v(RT,3'd2,0,0,1, 0,0,0,0,2'd0,2'd2,2'd0,2'd0,0,3'd5,0));
    tbl.push_back(v(RT,3'd2,0,0,1, 0,0,0,0,2'd0,2'd0,2'd0,2'd0,1,3'd0,0));
    // ori
    tbl.push_back(v(IT,3'd6,0,0,1, 1,0,0,1,2'd2,2'd0,2'd2,2'd0,0,3'd0,0));
    tbl.push_back(v(IT,3'd6,0,0,1, 0,0,0,0,2'd0,2'd1,2'd1,2'd0,0,3'd0,0));
    tbl.push_back(v(IT,3'd6,0,0,1, 0,0,0,0,2'd0,2'd2,2'd1,2'd0,0,3'd3,0));
    tbl.push_back(v(IT,3'd6,0,0,1, 0,0,0,0,2'd0,2'd0,2'd0,2'd0,1,3'd0,0));
    // addi with bit30 set stays add
    tbl.push_back(v(IT,3'd0,1,0,1, 1,0,0,1,2'd2,2'd0,2'd2,2'd0,0,3'd0,0));
    tbl.push_back(v(IT,3'd0,1,0,1, 0,0,0,0,2'd0,2'd1,2'd1,2'd0,0,3'd0,0));
    tbl.push_back(v(IT,3'd0,1,0,1, 0,0,0,0,2'd0,2'd2,2'd1,2'd0,0,3'd0,0));
    tbl.push_back(v(IT,3'd0,1,0,1, 0,0,0,0,2'd0,2'd0,2'd0,2'd0,1,3'd0,0));
    // beq Zero=1 taken
    tbl.push_back(v(BR,3'd0,0,1,1, 1,0,0,1,2'd2,2'd0,2'd2,2'd2,0,3'd0,0));
    tbl.push_back(v(BR,3'd0,0,1,1, 0,0,0,0,2'd0,2'd1,2'd1,2'd2,0,3'd0,0));
    tbl.push_back(v(BR,3'd0,0,1,1, 1,0,0,0,2'd0,2'd2,2'd0,2'd2,0,3'd1,0));
    // bne Zero=1 not taken
    tbl.push_back(v(BR,3'd1,0,1,1, 1,0,0,1,2'd2,2'd0,2'd2,2'd2,0,3'd0,0));
    tbl.push_back(v(BR,3'd1,0,1,1, 0,0,0,0,2'd0,2'd1,2'd1,2'd2,0,3'd0,0));
    tbl.push_back(v(BR,3'd1,0,1,1, 0,0,0,0,2'd0,2'd2,2'd0,2'd2,0,3'd1,0));
    // bne Zero=0 taken
    tbl.push_back(v(BR,3'd1,0,0,1, 1,0,0,1,2'd2,2'd0,2'd2,2'd2,0,3'd0,0));
    tbl.push_back(v(BR,3'd1,0,0,1, 0,0,0,0,2'd0,2'd1,2'd1,2'd2,0,3'd0,0));
    tbl.push_back(v(BR,3'd1,0,0,1, 1,0,0,0,2'd0,2'd2,2'd0,2'd2,0,3'd1,0));
    // funct3 100 never taken here
    tbl.push_back(v(BR,3'd4,0,1,1, 1,0,0,1,2'd2,2'd0,2'd2,2'd2,0,3'd0,0));
    tbl.push_back(v(BR,3'd4,0,1,1, 0,0,0,0,2'd0,2'd1,2'd1,2'd2,0,3'd0,0));
    tbl.push_back(v(BR,3'd4,0,1,1, 0,0,0,0,2'd0,2'd2,2'd0,2'd2,0,3'd1,0));
    // jal
    tbl.push_back(v(JL,3'd0,0,0,1, 1,0,0,1,2'd2,2'd0,2'd2,2'd3,0,3'd0,0));
    tbl.push_back(v(JL,3'd0,0,0,1, 0,0,0,0,2'd0,2'd1,2'd1,2'd3,0,3'd0,0));
    tbl.push_back(v(JL,3'd0,0,0,1, 1,0,0,0,2'd0,2'd1,2'd2,2'd3,0,3'd0,0));
    tbl.push_back(v(JL,3'd0,0,0,1, 0,0,0,0,2'd0,2'd0,2'd0,2'd3,1,3'd0,0));
    // illegal opcode
    tbl.push_back(v(BAD,3'd0,0,0,1, 1,0,0,1,2'd2,2'd0,2'd2,2'd0,0,3'd0,0));
    tbl.push_back(v(BAD,3'd0,0,0,1, 0,0,0,0,2'd0,2'd1,2'd1,2'd0,0,3'd0,1));

    @(negedge clk);
    apply(v(LW,3'd2,0,0,1, 0,0,0,0,2'd2,2'd0,2'd2,2'd0,0,3'd0,0), "reset");
    reset = 1'b0;

    foreach (tbl[i]) begin
      apply(tbl[i], $sformatf("row%0d", i));
      @(negedge clk);
    end

    // reset while MEMWRITE waits on memory
    apply(tbl[5], "rst_sw_f");  @(negedge clk);
    apply(tbl[6], "rst_sw_d");  @(negedge clk);
    apply(tbl[7], "rst_sw_ma"); @(negedge clk);
    apply(v(SW,3'd2,0,0,0, 0,1,1,0,2'd0,2'd0,2'd0,2'd1,0,3'd0,0), "rst_sw_mw");
    reset = 1'b1;
    apply(v(SW,3'd2,0,0,0, 0,0,0,0,2'd2,2'd0,2'd2,2'd1,0,3'd0,0), "rst_mid");
    @(negedge clk);
    reset = 1'b0;
    apply(tbl[5], "rst_fetch"); @(negedge clk);
    apply(tbl[6], "rst_d");     @(negedge clk);
    apply(tbl[7], "rst_ma");    @(negedge clk);
    apply(tbl[8], "rst_mw");    @(negedge clk);

`ifdef MCCTRL_MEM_WAIT_EN
    irw_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      apply(v(LW,3'd2,0,0,0, 0,0,0,0,2'd2,2'd0,2'd2,2'd0,0,3'd0,0), "stl_f");
      irw_cnt += int'(IRWrite);
      @(negedge clk);
    end
    apply(tbl[0], "stl_f_go"); irw_cnt += int'(IRWrite); @(negedge clk);
    apply(v(LW,3'd2,0,0,0, 0,0,0,0,2'd0,2'd1,2'd1,2'd0,0,3'd0,0), "stl_d");
    irw_cnt += int'(IRWrite); @(negedge clk);
    apply(tbl[2], "stl_ma"); irw_cnt += int'(IRWrite); @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      apply(v(LW,3'd2,0,0,0, 0,1,0,0,2'd0,2'd0,2'd0,2'd0,0,3'd0,0), "stl_mr");
      irw_cnt += int'(IRWrite);
      @(negedge clk);
    end
    apply(tbl[3], "stl_mr_go"); irw_cnt += int'(IRWrite); @(negedge clk);
    apply(tbl[4], "stl_mwb");   irw_cnt += int'(IRWrite); @(negedge clk);
    count_check(irw_cnt, 1, "stl_irw_pulses");
    apply(tbl[0], "stl_next_f"); @(negedge clk);
    apply(tbl[1], "stl_next_d"); @(negedge clk);
    apply(tbl[2], "stl_next_ma"); @(negedge clk);
    apply(tbl[3], "stl_next_mr"); @(negedge clk);
    apply(tbl[4], "stl_next_mwb"); @(negedge clk);
    // sw held in MEMWRITE
    apply(tbl[5], "stw_f");  @(negedge clk);
    apply(tbl[6], "stw_d");  @(negedge clk);
    apply(tbl[7], "stw_ma"); @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      apply(v(SW,3'd2,0,0,0, 0,1,1,0,2'd0,2'd0,2'd0,2'd1,0,3'd0,0), "stw_mw");
      @(negedge clk);
    end
    apply(tbl[8], "stw_mw_go"); @(negedge clk);
    apply(tbl[5], "stw_next_f"); @(negedge clk);
`else
    // MemReady low is ignored: lw still takes 5 cycles
    irw_cnt = 0;
    apply(v(LW,3'd2,0,0,0, 1,0,0,1,2'd2,2'd0,2'd2,2'd0,0,3'd0,0), "nw_f");
    irw_cnt += int'(IRWrite); @(negedge clk);
    apply(v(LW,3'd2,0,0,0, 0,0,0,0,2'd0,2'd1,2'd1,2'd0,0,3'd0,0), "nw_d");
    irw_cnt += int'(IRWrite); @(negedge clk);
    apply(v(LW,3'd2,0,0,0, 0,0,0,0,2'd0,2'd2,2'd1,2'd0,0,3'd0,0), "nw_ma");
    irw_cnt += int'(IRWrite); @(negedge clk);
    apply(v(LW,3'd2,0,0,0, 0,1,0,0,2'd0,2'd0,2'd0,2'd0,0,3'd0,0), "nw_mr");
    irw_cnt += int'(IRWrite); @(negedge clk);
    apply(v(LW,3'd2,0,0,0, 0,0,0,0,2'd1,2'd0,2'd0,2'd0,1,3'd0,0), "nw_mwb");
    irw_cnt += int'(IRWrite); @(negedge clk);
    count_check(irw_cnt, 1, "nw_irw_pulses");
    apply(v(SW,3'd2,0,0,0, 1,0,0,1,2'd2,2'd0,2'd2,2'd1,0,3'd0,0), "nw_sw_f");
    @(negedge clk);
    apply(v(SW,3'd2,0,0,0, 0,0,0,0,2'd0,2'd1,2'd1,2'd1,0,3'd0,0), "nw_sw_d");
    @(negedge clk);
    apply(v(SW,3'd2,0,0,0, 0,0,0,0,2'd0,2'd2,2'd1,2'd1,0,3'd0,0), "nw_sw_ma");
    @(negedge clk);
    apply(v(SW,3'd2,0,0,0, 0,1,1,0,2'd0,2'd0,2'd0,2'd1,0,3'd0,0), "nw_sw_mw");
    @(negedge clk);
    apply(v(SW,3'd2,0,0,0, 1,0,0,1,2'd2,2'd0,2'd2,2'd1,0,3'd0,0), "nw_sw_next");
    @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
